// File: rtl/vga_timing_pkg.sv
// Shared raster-timing types and the default 1280x1024@60 timing set.
package vga_timing_pkg;
  localparam int COORD_W   = 12;
  localparam int COORD_MAX = 4096;

  typedef enum logic [1:0] {ACT, FP, SYNC, BP} phase_t;

  localparam int DEF_H_ACTIVE = 1280;
  localparam int DEF_H_FP     = 48;
  localparam int DEF_H_SYNC   = 112;
  localparam int DEF_H_BP     = 248;
  localparam int DEF_V_ACTIVE = 1024;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BP     = 38;

  function automatic int seg_total(input int a, input int b, input int c, input int d);
    return a + b + c + d;
  endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus ACT/FP/SYNC/BP phase tracker.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int SEG_ACT  = DEF_H_ACTIVE,
  parameter int SEG_FP   = DEF_H_FP,
  parameter int SEG_SYNC = DEF_H_SYNC,
  parameter int SEG_BP   = DEF_H_BP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic [COORD_W-1:0] count,
  output phase_t             phase,
  output logic               wrap
);
  localparam int TOTAL = seg_total(SEG_ACT, SEG_FP, SEG_SYNC, SEG_BP);
  localparam logic [COORD_W-1:0] LAST_ACT  = COORD_W'(SEG_ACT - 1);
  localparam logic [COORD_W-1:0] LAST_FP   = COORD_W'(SEG_ACT + SEG_FP - 1);
  localparam logic [COORD_W-1:0] LAST_SYNC = COORD_W'(SEG_ACT + SEG_FP + SEG_SYNC - 1);
  localparam logic [COORD_W-1:0] LAST_ALL  = COORD_W'(TOTAL - 1);

  // Terminal count, not gated by en: the vertical axis qualifies it itself.
  assign wrap = (count == LAST_ALL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      phase <= ACT;
    end else if (en) begin
      count <= wrap ? '0 : count + 12'd1;
      case (phase)
        ACT:     if (count == LAST_ACT)  phase <= FP;
        FP:      if (count == LAST_FP)   phase <= SYNC;
        SYNC:    if (count == LAST_SYNC) phase <= BP;
        BP:      if (wrap)               phase <= ACT;
        default:                         phase <= ACT;
      endcase
    end
  end
endmodule

// File: rtl/vga_timing_gen.sv
// Raster scan generator: registered coordinates, syncs, active video and line/frame strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic               CLK_VGA,
  input  logic               RESET_N,
  input  logic               PIX_EN,
  output logic [COORD_W-1:0] VGA_horzCoord,
  output logic [COORD_W-1:0] VGA_vertCoord,
  output logic               VGA_active,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               LINE_START,
  output logic               FRAME_START
);
  localparam int H_TOTAL = seg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = seg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX ||
      H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_params
    $error("vga_timing_gen: timing parameters out of range");
  end

  logic [COORD_W-1:0] h, v;
  phase_t             h_phase, v_phase;
  logic               h_wrap, v_wrap;
  logic               origin;

  vga_axis_counter #(
    .SEG_ACT(H_ACTIVE), .SEG_FP(H_FP), .SEG_SYNC(H_SYNC), .SEG_BP(H_BP)
  ) u_h (
    .clk(CLK_VGA), .rst_n(RESET_N), .en(PIX_EN),
    .count(h), .phase(h_phase), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .SEG_ACT(V_ACTIVE), .SEG_FP(V_FP), .SEG_SYNC(V_SYNC), .SEG_BP(V_BP)
  ) u_v (
    .clk(CLK_VGA), .rst_n(RESET_N), .en(PIX_EN & h_wrap),
    .count(v), .phase(v_phase), .wrap(v_wrap)
  );

  // origin marks that the counters currently sit at (0,0); it replaces a wide compare.
  always_ff @(posedge CLK_VGA or negedge RESET_N) begin
    if (!RESET_N) begin
      VGA_horzCoord <= '0;
      VGA_vertCoord <= '0;
      VGA_active    <= 1'b0;
      VGA_HS        <= ~HS_POL;
      VGA_VS        <= ~VS_POL;
      LINE_START    <= 1'b0;
      FRAME_START   <= 1'b0;
      origin        <= 1'b1;
    end else begin
      LINE_START  <= PIX_EN && (h == '0);
      FRAME_START <= PIX_EN && origin;
      if (PIX_EN) begin
        VGA_horzCoord <= h;
        VGA_vertCoord <= v;
        VGA_active    <= (h_phase == ACT) && (v_phase == ACT);
        VGA_HS        <= (h_phase == SYNC) ? HS_POL : ~HS_POL;
        VGA_VS        <= (v_phase == SYNC) ? VS_POL : ~VS_POL;
        origin        <= h_wrap && v_wrap;
      end
    end
  end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the raster scan that drives the oscilloscope display. It maintains horizontal and vertical pixel counters, decodes blanking and sync intervals, and publishes registered 12-bit `VGA_horzCoord` / `VGA_vertCoord` plus sync, active-video and frame/line strobes. It sits directly upstream of every glyph and trace renderer (digit conditions, grid, waveform) and of the final pixel colour mux, all of which compare against these coordinates combinationally.

## Interface
Parameters:
- `H_ACTIVE`, 1280, visible pixels per line
- `H_FP`, 48, horizontal front porch (pixels)
- `H_SYNC`, 112, horizontal sync width (pixels)
- `H_BP`, 248, horizontal back porch (pixels)
- `V_ACTIVE`, 1024, visible lines per frame
- `V_FP`, 1, vertical front porch (lines)
- `V_SYNC`, 3, vertical sync width (lines)
- `V_BP`, 38, vertical back porch (lines)
- `HS_POL`, 1, asserted level of `VGA_HS`
- `VS_POL`, 1, asserted level of `VGA_VS`

Ports:
- `CLK_VGA` in 1: pixel-domain clock; the block has one clock.
- `RESET_N` in 1: reset, asynchronous, active-low.
- `PIX_EN` in 1: pixel clock enable; the raster advances only on enabled edges.
- `VGA_horzCoord` out 12: current column, 0..H_TOTAL-1.
- `VGA_vertCoord` out 12: current row, 0..V_TOTAL-1.
- `VGA_active` out 1: high when column < H_ACTIVE and row < V_ACTIVE.
- `VGA_HS` out 1: horizontal sync, level per `HS_POL`.
- `VGA_VS` out 1: vertical sync, level per `VS_POL`.
- `LINE_START` out 1: one-`CLK_VGA` pulse when column 0 is presented.
- `FRAME_START` out 1: one-`CLK_VGA` pulse when (0,0) is presented.

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1688). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 1066). Elaboration error if either total exceeds 4096 or any parameter is 0.
- Internal counters `h` and `v` are both 12-bit unsigned with no overflow path.
  - `h` increments on each enabled edge and wraps from H_TOTAL-1 to 0.
  - `v` increments only on an `h` wrap, and wraps from V_TOTAL-1 to 0 when that coincides with an `h` wrap.
- Horizontal phase FSM: H_ACT → H_FP → H_SYNC → H_BP → H_ACT. Each transition happens on the enabled edge where `h` reaches that phase's last count.
- Vertical phase FSM: V_ACT → V_FP → V_SYNC → V_BP → V_ACT. It steps only on `h` wraps.
- Output decode:
  - Sync is asserted in the SYNC phase: HS for columns [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], VS for rows [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
  - `VGA_active` = H_ACT and V_ACT.
  - Coordinates carry the raw counter values during blanking as well; consumers qualify with `VGA_active`.
- `PIX_EN` low: counters, FSMs, coordinates, `VGA_active`, `VGA_HS` and `VGA_VS` all hold. `LINE_START` and `FRAME_START` are driven 0.
- Reset (asynchronous, any time, including mid-frame):
  - Counters go to 0 and both FSMs go to ACT.
  - Coordinates go to 0; `VGA_active`, `LINE_START` and `FRAME_START` go to 0.
  - `VGA_HS` goes to ~HS_POL and `VGA_VS` to ~VS_POL.

## Timing
- Every output is registered. On each enabled edge the outputs take the decode of the pre-increment (`h`,`v`). Outputs therefore lag the counters by one enabled edge, and all outputs stay mutually aligned.
- The first enabled edge after `RESET_N` deasserts presents (0,0) with `VGA_active`=1, `LINE_START`=1 and `FRAME_START`=1.
- Line period is H_TOTAL enabled edges; frame period is H_TOTAL×V_TOTAL enabled edges.
- `LINE_START` and `FRAME_START` are high for exactly one `CLK_VGA` cycle, whatever the `PIX_EN` duty.
- Downstream combinational renderers see stable coordinates for the whole enabled interval.

## Structure
- Shared package `vga_timing_pkg`:
  - phase enum {ACT, FP, SYNC, BP}
  - default 1280×1024@60 timing constants
  - coordinate width constant (12)
- Sub-module `vga_axis_counter` is instantiated twice:
  - Parameters: segment lengths.
  - Ports: in `en`; out count, phase, `wrap`.
  - Horizontal instance: `en` = `PIX_EN`.
  - Vertical instance: `en` = `PIX_EN` & horizontal `wrap`.

## Test plan
- `PIX_EN` tied 1, release reset → first edge: coord (0,0), `VGA_active`=1, `FRAME_START`=`LINE_START`=1, `VGA_HS`=`VGA_VS`=0. Next edge: (1,0), strobes 0.
- Row 0 horizontal sweep → `VGA_active`=1 at col 1279, 0 at col 1280. `VGA_HS`=1 for cols 1328..1439 (112 edges). Col 1687 is followed by (0,1) with `LINE_START`=1.
- Full frame → `VGA_VS`=1 on rows 1025..1027 only. Consecutive `FRAME_START` pulses are 1,799,408 enabled edges apart. After (1687,1065) the next coordinate is (0,0).
- `PIX_EN` alternating 1/0 → outputs change only after enabled edges. Each strobe is high exactly one clock. Frame period is 3,598,816 clocks.
- Assert `RESET_N` asynchronously at (700,500) mid-cycle → all outputs reach reset values before the next edge. After release the sequence restarts at (0,0).
- Override to H 4/1/2/1, V 3/1/1/1, `HS_POL`=`VS_POL`=0 → exhaustive compare over 3 frames against a reference model. Sync is active-low; H_TOTAL=8, V_TOTAL=6.
